fn_sw_rr: RTL and testbench

//  N-channel, W-bit registered switch; the parametrised successor of the 2:1 fn_sw selector.

---
 rtl/fn_sw_pkg.sv | 15 +
 rtl/fn_sw_rr_pick.sv | 47 ++++
 rtl/fn_sw_rr.sv | 124 ++++++++++++
 tb/tb_fn_sw_rr.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fn_sw_pkg.sv
// Package: fn_sw_pkg
// Purpose: Shared constants and helpers for the fn_sw_rr switch family.
//   MODE_FIXED / MODE_RR : values of the mode input
//   clog2_min1           : index width for N channels, never below 1 bit
package fn_sw_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // A 2-channel switch still needs one select bit, so clamp to 1.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fn_sw_rr_pick.sv
// Module: fn_sw_rr_pick
// Purpose: Combinational round-robin picker. Finds the first asserted request
//   at or after ptr+1, wrapping modulo N.
// Ports:
//   req     in   N     request vector
//   ptr     in   SELW  index of the most recently granted channel
//   gnt_vld out  1     some request was found
//   gnt_idx out  SELW  index of the chosen request (0 when gnt_vld=0)
module fn_sw_rr_pick
  import fn_sw_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  logic [N-1:0] w_rot;
  logic         w_found;
  int           w_pos;
  int           w_src;

  // Rotate so that bit 0 of w_rot is channel ptr+1, priority-encode the lowest
  // set bit, then map the position back to a real channel index.
  always_comb begin
    w_rot   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    w_src   = 0;
    for (int j = 0; j < N; j++) begin
      w_src    = (int'(ptr) + 1 + j) % N;
      w_rot[j] = req[w_src];
    end
    for (int j = 0; j < N; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_pos   = j;
      end
    end
    gnt_vld = w_found;
    gnt_idx = w_found ? SELW'((int'(ptr) + 1 + w_pos) % N) : '0;
  end

endmodule

// File: rtl/fn_sw_rr.sv
// Module: fn_sw_rr
// Purpose: N-channel, W-bit registered switch. One channel per cycle is forwarded
//   into a single output register, chosen either by a fixed select or round-robin.
//   Completed output transfers are counted in a wrapping counter.
// Ports:
//   clk       in   1     rising-edge clock
//   rst_n     in   1     synchronous active-low reset
//   mode      in   1     MODE_FIXED (use sel) or MODE_RR (round-robin)
//   sel       in   SELW  channel index used in MODE_FIXED
//   in_valid  in   N     per-channel valid
//   in_ready  out  N     per-channel ready, one-hot or zero
//   in_data   in   N*W   channel i at in_data[i*W +: W]
//   out_valid out  1     output register holds valid data
//   out_ready in   1     consumer accepts when out_valid & out_ready
//   out_data  out  W     registered data
//   out_chan  out  SELW  source channel of out_data
//   xfer_cnt  out  CW    completed output transfers, wraps silently
module fn_sw_rr
  import fn_sw_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 16,
  localparam int SELW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic [CW-1:0]   xfer_cnt
);

  logic            r_outValid;
  logic [W-1:0]    r_outData;
  logic [SELW-1:0] r_outChan;
  logic [SELW-1:0] r_ptr;
  logic [CW-1:0]   r_xferCnt;

  logic            w_load;
  logic            w_fixedVld;
  logic            w_pickVld;
  logic [SELW-1:0] w_pickIdx;
  logic            w_gntVld;
  logic [SELW-1:0] w_gntIdx;
  logic [W-1:0]    w_gntData;

  // The register can take a new word when it is empty or being drained this cycle.
  assign w_load = !r_outValid || out_ready;

  fn_sw_rr_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_vld (w_pickVld),
    .gnt_idx (w_pickIdx)
  );

  // Fixed select: matching sel against each legal index means an out-of-range
  // sel (possible when N is not a power of two) simply grants nothing.
  always_comb begin
    w_fixedVld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) w_fixedVld = in_valid[i];
    end
  end

  always_comb begin
    w_gntVld = 1'b0;
    w_gntIdx = '0;
    if (mode == MODE_RR) begin
      w_gntVld = w_load && w_pickVld;
      w_gntIdx = w_pickIdx;
    end else begin
      w_gntVld = w_load && w_fixedVld;
      w_gntIdx = sel;
    end
  end

  // Ready is forced low during reset so no producer believes a word was taken.
  always_comb begin
    in_ready  = '0;
    w_gntData = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && w_gntVld && (w_gntIdx == SELW'(i));
      if (w_gntIdx == SELW'(i)) w_gntData = in_data[i*W +: W];
    end
  end

  // Output register, round-robin pointer and transfer counter. A drain and a new
  // grant in the same cycle both happen: the counter ticks and the word is replaced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outChan  <= '0;
      r_ptr      <= SELW'(N - 1);
      r_xferCnt  <= '0;
    end else begin
      if (r_outValid && out_ready) r_xferCnt <= r_xferCnt + CW'(1);
      if (w_load) begin
        if (w_gntVld) begin
          r_outValid <= 1'b1;
          r_outData  <= w_gntData;
          r_outChan  <= w_gntIdx;
          if (mode == MODE_RR) r_ptr <= w_gntIdx;
        end else begin
          r_outValid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_chan  = r_outChan;
  assign xfer_cnt  = r_xferCnt;

endmodule

// File: tb/tb_fn_sw_rr.sv
// Testbench: tb_fn_sw_rr
// Purpose: Self-checking bench for fn_sw_rr. DUT A (N=4, W=8, CW=16) is checked
//   against a behavioural model of the switch; DUT B (N=5, CW=4) covers the
//   out-of-range select and counter wrap cases.
module tb_fn_sw_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // DUT A signals
  logic        rstN;
  logic        modeA;
  logic [1:0]  selA;
  logic [3:0]  validA;
  logic [3:0]  readyA;
  logic [31:0] dataA;
  logic        outValidA;
  logic        outReadyA;
  logic [7:0]  outDataA;
  logic [1:0]  outChanA;
  logic [15:0] cntA;

  // DUT B signals
  logic        rstNB;
  logic        modeB;
  logic [2:0]  selB;
  logic [4:0]  validB;
  logic [4:0]  readyB;
  logic [39:0] dataB;
  logic        outValidB;
  logic        outReadyB;
  logic [7:0]  outDataB;
  logic [2:0]  outChanB;
  logic [3:0]  cntB;

  fn_sw_rr #(.N(4), .W(8), .CW(16)) dutA (
    .clk(clk), .rst_n(rstN), .mode(modeA), .sel(selA),
    .in_valid(validA), .in_ready(readyA), .in_data(dataA),
    .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA),
    .out_chan(outChanA), .xfer_cnt(cntA)
  );

  fn_sw_rr #(.N(5), .W(8), .CW(4)) dutB (
    .clk(clk), .rst_n(rstNB), .mode(modeB), .sel(selB),
    .in_valid(validB), .in_ready(readyB), .in_data(dataB),
    .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB),
    .out_chan(outChanB), .xfer_cnt(cntB)
  );

  // Reference model state for DUT A
  bit aValid;
  int aData;
  int aChan;
  int aCnt;
  int aPtr;

  // Which channel the switch should take: fixed picks sel if it is legal and
  // valid; round-robin walks ptr+1, ptr+2, ... modulo n. -1 means none.
  function automatic int pickModel(int n, logic md, int s, logic [7:0] v, int p);
    int c;
    if (md == 1'b0) begin
      if (s < n) begin
        if (v[s]) return s;
      end
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      c = (p + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] predReadyA();
    int g;
    if (!rstN) return 4'b0;
    if (aValid && !outReadyA) return 4'b0;
    g = pickModel(4, modeA, int'(selA), {4'b0, validA}, aPtr);
    if (g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  function automatic logic [26:0] expOutA();
    return {aValid, 8'(aData), 2'(aChan), 16'(aCnt)};
  endfunction

  // Advance one clock and update the model from the inputs seen before the edge.
  task automatic tickA();
    int         g;
    logic       ld;
    logic       md;
    logic       rdy;
    logic       rst;
    logic [7:0] d;
    ld  = !aValid || outReadyA;
    md  = modeA;
    rdy = outReadyA;
    rst = rstN;
    g   = ld ? pickModel(4, modeA, int'(selA), {4'b0, validA}, aPtr) : -1;
    d   = (g >= 0) ? dataA[g*8 +: 8] : 8'h00;
    @(posedge clk);
    #1;
    if (!rst) begin
      aValid = 1'b0; aData = 0; aChan = 0; aCnt = 0; aPtr = 3;
    end else begin
      if (aValid && rdy) aCnt = (aCnt + 1) % 65536;
      if (ld) begin
        if (g >= 0) begin
          aValid = 1'b1; aData = int'(d); aChan = g;
          if (md) aPtr = g;
        end else begin
          aValid = 1'b0;
        end
      end
    end
  endtask

  task automatic tickB();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; modeA = 1'b1; selA = 2'd0; validA = 4'hF;
    dataA = $urandom; outReadyA = 1'b1;
    #2;
    nTests++;
    if (readyA !== 4'b0) begin
      nFail++; $display("[TB] FAIL reset_ready: got %b, want 0000", readyA);
    end
    tickA();
    tickA();
    nTests++;
    if ({outValidA, outDataA, cntA} !== 25'd0) begin
      nFail++;
      $display("[TB] FAIL reset_state: got v=%b d=%h cnt=%0d, want v=0 d=00 cnt=0",
               outValidA, outDataA, cntA);
    end
    nTests++;
    if ({outValidA, outDataA, outChanA, cntA} !== expOutA()) begin
      nFail++; $display("[TB] FAIL reset_model: got %h, want %h",
                        {outValidA, outDataA, outChanA, cntA}, expOutA());
    end
    rstN = 1'b1;
  endtask

  task automatic test_rr();
    modeA = 1'b1; validA = 4'hF; outReadyA = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dataA = $urandom;
      #2;
      nTests++;
      if (readyA !== 4'(1 << (k % 4))) begin
        nFail++; $display("[TB] FAIL rr_ready k=%0d: got %b, want %b", k, readyA, 4'(1 << (k % 4)));
      end
      tickA();
      nTests++;
      if (outChanA !== 2'(k % 4) || {outValidA, outDataA, outChanA, cntA} !== expOutA()) begin
        nFail++; $display("[TB] FAIL rr_out k=%0d: got chan=%0d all=%h, want chan=%0d all=%h",
                          k, outChanA, {outValidA, outDataA, outChanA, cntA}, k % 4, expOutA());
      end
    end
    validA = 4'h0;
    #2;
    tickA();
    nTests++;
    if (cntA !== 16'd8 || outValidA !== 1'b0) begin
      nFail++; $display("[TB] FAIL rr_count: got cnt=%0d v=%b, want cnt=8 v=0", cntA, outValidA);
    end
  endtask

  task automatic test_backpressure();
    int saved;
    modeA = 1'b1; validA = 4'b0010; outReadyA = 1'b1;
    dataA = $urandom; dataA[15:8] = 8'h3C;
    #2;
    tickA();
    saved = aCnt;
    outReadyA = 1'b0; validA = 4'hF;
    for (int k = 0; k < 3; k++) begin
      dataA = $urandom;
      #2;
      nTests++;
      if (readyA !== 4'b0) begin
        nFail++; $display("[TB] FAIL stall_ready k=%0d: got %b, want 0000", k, readyA);
      end
      tickA();
      nTests++;
      if (outDataA !== 8'h3C || outValidA !== 1'b1 || outChanA !== 2'd1 || cntA !== 16'(saved)) begin
        nFail++; $display("[TB] FAIL stall_hold k=%0d: got d=%h v=%b ch=%0d cnt=%0d, want d=3c v=1 ch=1 cnt=%0d",
                          k, outDataA, outValidA, outChanA, cntA, saved);
      end
    end
    outReadyA = 1'b1;
    #2;
    nTests++;
    if (readyA !== 4'b0100) begin
      nFail++; $display("[TB] FAIL release_ready: got %b, want 0100", readyA);
    end
    tickA();
    nTests++;
    if (outChanA !== 2'd2 || cntA !== 16'(saved + 1)) begin
      nFail++; $display("[TB] FAIL release_out: got ch=%0d cnt=%0d, want ch=2 cnt=%0d",
                        outChanA, cntA, saved + 1);
    end
  endtask

  task automatic test_fixed();
    modeA = 1'b0; selA = 2'd2; validA = 4'b0100; outReadyA = 1'b1;
    dataA = $urandom; dataA[23:16] = 8'hA5;
    #2;
    nTests++;
    if (readyA !== 4'b0100) begin
      nFail++; $display("[TB] FAIL fixed_ready: got %b, want 0100", readyA);
    end
    tickA();
    nTests++;
    if (outDataA !== 8'hA5 || outChanA !== 2'd2 || outValidA !== 1'b1) begin
      nFail++; $display("[TB] FAIL fixed_out: got d=%h ch=%0d v=%b, want d=a5 ch=2 v=1",
                        outDataA, outChanA, outValidA);
    end
    for (int k = 0; k < 8; k++) begin
      selA = 2'($urandom); validA = 4'($urandom); dataA = $urandom;
      outReadyA = ($urandom_range(0, 3) != 0);
      #2;
      nTests++;
      if (readyA !== predReadyA()) begin
        nFail++; $display("[TB] FAIL fixed_rand_ready k=%0d: got %b, want %b", k, readyA, predReadyA());
      end
      tickA();
      nTests++;
      if ({outValidA, outDataA, outChanA, cntA} !== expOutA()) begin
        nFail++; $display("[TB] FAIL fixed_rand_out k=%0d: got %h, want %h",
                          k, {outValidA, outDataA, outChanA, cntA}, expOutA());
      end
    end
  endtask

  task automatic test_sparse();
    int        expSeq [4] = '{3, 0, 3, 0};
    logic [7:0] held;
    modeA = 1'b1; validA = 4'b0001; outReadyA = 1'b1; dataA = $urandom;
    #2;
    tickA();
    validA = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      dataA = $urandom;
      #2;
      tickA();
      nTests++;
      if (outChanA !== 2'(expSeq[k]) || {outValidA, outDataA, outChanA, cntA} !== expOutA()) begin
        nFail++; $display("[TB] FAIL sparse_rr k=%0d: got ch=%0d all=%h, want ch=%0d all=%h",
                          k, outChanA, {outValidA, outDataA, outChanA, cntA}, expSeq[k], expOutA());
      end
    end
    held = 8'(aData);
    outReadyA = 1'b0; modeA = 1'b0; selA = 2'd0; dataA = $urandom;
    #2;
    nTests++;
    if (readyA !== 4'b0) begin
      nFail++; $display("[TB] FAIL switch_ready: got %b, want 0000", readyA);
    end
    tickA();
    nTests++;
    if (outValidA !== 1'b1 || outDataA !== held || outChanA !== 2'd0) begin
      nFail++; $display("[TB] FAIL switch_hold: got v=%b d=%h ch=%0d, want v=1 d=%h ch=0",
                        outValidA, outDataA, outChanA, held);
    end
    outReadyA = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dataA = $urandom;
      #2;
      nTests++;
      if (readyA !== 4'b0001) begin
        nFail++; $display("[TB] FAIL fixed0_ready k=%0d: got %b, want 0001", k, readyA);
      end
      tickA();
      nTests++;
      if ({outValidA, outDataA, outChanA, cntA} !== expOutA()) begin
        nFail++; $display("[TB] FAIL fixed0_out k=%0d: got %h, want %h",
                          k, {outValidA, outDataA, outChanA, cntA}, expOutA());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      modeA = 1'($urandom); selA = 2'($urandom); validA = 4'($urandom);
      dataA = $urandom; outReadyA = ($urandom_range(0, 3) != 0);
      #2;
      nTests++;
      if (readyA !== predReadyA()) begin
        nFail++; $display("[TB] FAIL rand_ready k=%0d: got %b, want %b", k, readyA, predReadyA());
      end
      tickA();
      nTests++;
      if ({outValidA, outDataA, outChanA, cntA} !== expOutA()) begin
        nFail++; $display("[TB] FAIL rand_out k=%0d: got %h, want %h",
                          k, {outValidA, outDataA, outChanA, cntA}, expOutA());
      end
    end
  endtask

  task automatic test_sel_range();
    rstNB = 1'b0; modeB = 1'b0; selB = 3'd5; validB = 5'h1F;
    dataB = {8'h44, 32'($urandom)}; outReadyB = 1'b1;
    tickB();
    tickB();
    rstNB = 1'b1;
    #2;
    nTests++;
    if (readyB !== 5'b0) begin
      nFail++; $display("[TB] FAIL sel5_ready: got %b, want 00000", readyB);
    end
    tickB();
    nTests++;
    if (outValidB !== 1'b0) begin
      nFail++; $display("[TB] FAIL sel5_out: got v=%b, want v=0", outValidB);
    end
    selB = 3'd4;
    #2;
    nTests++;
    if (readyB !== 5'b10000) begin
      nFail++; $display("[TB] FAIL sel4_ready: got %b, want 10000", readyB);
    end
    tickB();
    nTests++;
    if (outValidB !== 1'b1 || outChanB !== 3'd4 || outDataB !== 8'h44) begin
      nFail++; $display("[TB] FAIL sel4_out: got v=%b ch=%0d d=%h, want v=1 ch=4 d=44",
                        outValidB, outChanB, outDataB);
    end
  endtask

  task automatic test_wrap();
    rstNB = 1'b0;
    tickB();
    rstNB = 1'b1; modeB = 1'b1; validB = 5'h1F; outReadyB = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      dataB = {8'($urandom), 32'($urandom)};
      tickB();
      if (k == 17) begin
        nTests++;
        if (cntB !== 4'd0) begin
          nFail++; $display("[TB] FAIL wrap_zero: got cnt=%0d, want 0", cntB);
        end
      end
    end
    nTests++;
    if (cntB !== 4'd1 || outValidB !== 1'b1) begin
      nFail++; $display("[TB] FAIL wrap_cnt: got cnt=%0d v=%b, want cnt=1 v=1", cntB, outValidB);
    end
    rstNB = 1'b0;
    #2;
    nTests++;
    if (readyB !== 5'b0) begin
      nFail++; $display("[TB] FAIL midreset_ready: got %b, want 00000", readyB);
    end
    tickB();
    nTests++;
    if (outValidB !== 1'b0 || cntB !== 4'd0) begin
      nFail++; $display("[TB] FAIL midreset_out: got v=%b cnt=%0d, want v=0 cnt=0", outValidB, cntB);
    end
    rstNB = 1'b1;
  endtask

  initial begin
    rstNB = 1'b0; modeB = 1'b0; selB = 3'd0; validB = 5'h0; dataB = '0; outReadyB = 1'b0;
    aValid = 1'b0; aData = 0; aChan = 0; aCnt = 0; aPtr = 3;
    test_reset();
    test_rr();
    test_backpressure();
    test_fixed();
    test_sparse();
    test_random();
    rstN = 1'b0;
    test_sel_range();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
